// File: rtl/decode_pkg.sv
// Decode-stage ISA table: opcodes, execute/branch encodings, control word.
// Shared by decode_stage and decode_regfile.
package decode_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_JMP  = 6'd42;

  typedef enum logic [3:0] {
    EXE_ADD = 4'd0,
    EXE_SUB = 4'd2,
    EXE_AND = 4'd4,
    EXE_OR  = 4'd5,
    EXE_XOR = 4'd6
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  typedef struct packed {
    exe_cmd_e exe_cmd;
    br_type_e br_type;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     wb_en;
    logic     is_imm;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c.exe_cmd  = EXE_ADD;
    c.br_type  = BR_NONE;
    c.mem_r_en = 1'b0;
    c.mem_w_en = 1'b0;
    c.wb_en    = 1'b0;
    c.is_imm   = 1'b0;
    unique case (op)
      OP_ADD: c.wb_en = 1'b1;
      OP_SUB: begin
        c.exe_cmd = EXE_SUB;
        c.wb_en   = 1'b1;
      end
      OP_AND: begin
        c.exe_cmd = EXE_AND;
        c.wb_en   = 1'b1;
      end
      OP_OR: begin
        c.exe_cmd = EXE_OR;
        c.wb_en   = 1'b1;
      end
      OP_XOR: begin
        c.exe_cmd = EXE_XOR;
        c.wb_en   = 1'b1;
      end
      OP_ADDI: begin
        c.wb_en  = 1'b1;
        c.is_imm = 1'b1;
      end
      OP_LD: begin
        c.mem_r_en = 1'b1;
        c.wb_en    = 1'b1;
        c.is_imm   = 1'b1;
      end
      OP_ST: begin
        c.mem_w_en = 1'b1;
        c.is_imm   = 1'b1;
      end
      OP_BEZ: begin
        c.br_type = BR_BEZ;
        c.is_imm  = 1'b1;
      end
      OP_JMP: begin
        c.br_type = BR_JMP;
        c.is_imm  = 1'b1;
      end
      default: c.is_imm = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: 2 async read ports, 1 write port, r0 hardwired to zero.
// DECODE_WB_BYPASS_EN makes reads see a same-cycle write (write-first).
import decode_pkg::*;

module decode_regfile #(
  parameter  int DATA_W  = 32,
  parameter  int REG_NUM = 32,
  localparam int ADDR_W  = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [REG_NUM];
  logic [DATA_W-1:0] mem_d [REG_NUM];
  logic              wr_hit;
  logic              byp1;
  logic              byp2;

  assign wr_hit = we && (waddr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign byp1 = wr_hit && (waddr == raddr1);
  assign byp2 = wr_hit && (waddr == raddr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rdata1 = (raddr1 == '0) ? '0
                : byp1 ? wdata : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0
                : byp2 ? wdata : mem_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field/control decode, regfile read, load-use stall, ID/EX reg.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle write-back into reads.
import decode_pkg::*;

module decode_stage #(
  parameter  int DATA_W     = 32,
  parameter  int REG_NUM    = 32,
  parameter  int IMM_W      = 16,
  localparam int REG_ADDR_W = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           instruction,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  wb_write_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  exe_ready,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     val1,
  output logic [DATA_W-1:0]     val2,
  output logic [DATA_W-1:0]     reg2,
  output logic [1:0]            br_type,
  output logic [3:0]            exe_cmd,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  wb_en
);

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic [REG_ADDR_W-1:0] rd;
  logic [IMM_W-1:0]      imm;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     rdata1;
  logic [DATA_W-1:0]     rdata2;
  ctrl_t                 ctrl;
  logic                  advance;
  logic                  hazard;
  logic                  ld_pending;

  logic                  out_valid_q, out_valid_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     val1_q, val1_d;
  logic [DATA_W-1:0]     val2_q, val2_d;
  logic [DATA_W-1:0]     reg2_q, reg2_d;
  logic [1:0]            br_type_q, br_type_d;
  logic [3:0]            exe_cmd_q, exe_cmd_d;
  logic                  mem_r_en_q, mem_r_en_d;
  logic                  mem_w_en_q, mem_w_en_d;
  logic                  wb_en_q, wb_en_d;

  assign opcode  = instruction[31:26];
  assign src1    = instruction[21 +: REG_ADDR_W];
  assign src2    = instruction[16 +: REG_ADDR_W];
  assign rd      = instruction[11 +: REG_ADDR_W];
  assign imm     = instruction[IMM_W-1:0];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign ctrl    = decode_ctrl(opcode);

  decode_regfile #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_write_en),
    .waddr  (wb_dest),
    .wdata  (wb_data),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // ST reads src2 as store data even though it is an immediate op
  assign ld_pending = out_valid_q && mem_r_en_q && (dest_q != '0);
  assign hazard     = ld_pending &&
                      ((dest_q == src1) ||
                       ((dest_q == src2) &&
                        (!ctrl.is_imm || opcode == OP_ST)));
  assign advance    = !out_valid_q || exe_ready;
  assign in_ready   = advance && !hazard && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    dest_d      = dest_q;
    val1_d      = val1_q;
    val2_d      = val2_q;
    reg2_d      = reg2_q;
    br_type_d   = br_type_q;
    exe_cmd_d   = exe_cmd_q;
    mem_r_en_d  = mem_r_en_q;
    mem_w_en_d  = mem_w_en_q;
    wb_en_d     = wb_en_q;
    if (flush || (advance && (!in_valid || hazard))) begin
      out_valid_d = 1'b0;
      mem_r_en_d  = 1'b0;
      mem_w_en_d  = 1'b0;
      wb_en_d     = 1'b0;
    end else if (advance) begin
      out_valid_d = 1'b1;
      dest_d      = ctrl.is_imm ? src2 : rd;
      val1_d      = rdata1;
      val2_d      = ctrl.is_imm ? imm_ext : rdata2;
      reg2_d      = rdata2;
      br_type_d   = ctrl.br_type;
      exe_cmd_d   = ctrl.exe_cmd;
      mem_r_en_d  = ctrl.mem_r_en;
      mem_w_en_d  = ctrl.mem_w_en;
      wb_en_d     = ctrl.wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
      val1_q      <= '0;
      val2_q      <= '0;
      reg2_q      <= '0;
      br_type_q   <= '0;
      exe_cmd_q   <= '0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      wb_en_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dest_q      <= dest_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      reg2_q      <= reg2_d;
      br_type_q   <= br_type_d;
      exe_cmd_q   <= exe_cmd_d;
      mem_r_en_q  <= mem_r_en_d;
      mem_w_en_q  <= mem_w_en_d;
      wb_en_q     <= wb_en_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dest      = dest_q;
  assign val1      = val1_q;
  assign val2      = val2_q;
  assign reg2      = reg2_q;
  assign br_type   = br_type_q;
  assign exe_cmd   = exe_cmd_q;
  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign wb_en     = wb_en_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, queued expectations.
// Build with +define+DECODE_WB_BYPASS_EN to expect write-first reads.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] reg2;
    logic [1:0]  br;
    logic [3:0]  exe;
    logic        mr;
    logic        mw;
    logic        wb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        wb_write_en = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic        exe_ready = 1'b1;
  logic        out_valid;
  logic [4:0]  dest;
  logic [31:0] val1, val2, reg2;
  logic [1:0]  br_type;
  logic [3:0]  exe_cmd;
  logic        mem_r_en, mem_w_en, wb_en;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic ov_seen;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .instruction(instruction), .in_ready(in_ready),
    .flush(flush), .wb_write_en(wb_write_en),
    .wb_dest(wb_dest), .wb_data(wb_data),
    .exe_ready(exe_ready), .out_valid(out_valid),
    .dest(dest), .val1(val1), .val2(val2), .reg2(reg2),
    .br_type(br_type), .exe_cmd(exe_cmd),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic exp_t mk(
    input logic [4:0] d, input logic [31:0] v1,
    input logic [31:0] v2, input logic [31:0] r2,
    input logic [1:0] b, input logic [3:0] e,
    input logic mr, input logic mw, input logic wb);
    mk = '{dest:d, val1:v1, val2:v2, reg2:r2, br:b,
           exe:e, mr:mr, mw:mw, wb:wb};
  endfunction

  function automatic logic [31:0] rt(
    input logic [5:0] op, input logic [4:0] s1,
    input logic [4:0] s2, input logic [4:0] d);
    rt = {op, s1, s2, d, 11'd0};
  endfunction

  function automatic logic [31:0] it(
    input logic [5:0] op, input logic [4:0] s1,
    input logic [4:0] s2, input logic [15:0] im);
    it = {op, s1, s2, im};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] v);
    wb_write_en = 1'b1;
    wb_dest     = d;
    wb_data     = v;
    step();
    wb_write_en = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [31:0] ins,
                       input exp_t e, input int stalls);
    int  st = 0;
    bit  ok = 0;
    instruction = ins;
    in_valid    = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ov_seen = out_valid;
        ok = 1;
      end else begin
        st++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk({nm, "_stalls"}, 64'(st), 64'(stalls));
  endtask

  // Monitor: every consumed output must match the oldest expectation
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst) begin
      act = '{dest:dest, val1:val1, val2:val2, reg2:reg2,
              br:br_type, exe:exe_cmd, mr:mem_r_en,
              mw:mem_w_en, wb:wb_en};
      if (out_valid && exe_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got=%h", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL output got=%h want=%h", act, e);
          end
        end
      end
      if (!out_valid) begin
        checks++;
        if ({mem_r_en, mem_w_en, wb_en} !== 3'b000) begin
          failures++;
          $display("FAIL idle_enables got=%b want=000",
                   {mem_r_en, mem_w_en, wb_en});
        end
      end
    end
  end

  localparam logic [31:0] A5 = 32'hA5A5_A5A5;

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] R7_SAME = A5;
`else
  localparam logic [31:0] R7_SAME = 32'h11;
`endif

  initial begin
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_dest", 64'(dest), 0);
    chk("rst_val1", 64'(val1), 0);
    chk("rst_val2", 64'(val2), 0);
    chk("rst_reg2", 64'(reg2), 0);
    chk("rst_ctl", 64'({br_type, exe_cmd}), 0);
    step();

    wb(5'd1, 32'h100);
    wb(5'd2, 32'd7);
    wb(5'd3, 32'd5);
    wb(5'd7, 32'h11);

    issue("addi", it(6'd32, 5'd3, 5'd4, 16'hFFFE),
          mk(4, 5, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 1), 0);
    issue("add", rt(6'd1, 5'd1, 5'd2, 5'd8),
          mk(8, 32'h100, 7, 7, 0, 0, 0, 0, 1), 0);
    issue("sub", rt(6'd3, 5'd2, 5'd3, 5'd9),
          mk(9, 7, 5, 5, 0, 2, 0, 0, 1), 0);
    issue("bez", it(6'd40, 5'd2, 5'd0, 16'd8),
          mk(0, 7, 8, 0, 1, 0, 0, 0, 0), 0);

    issue("ld1", it(6'd36, 5'd1, 5'd5, 16'd0),
          mk(5, 32'h100, 0, 0, 0, 0, 1, 0, 1), 0);
    issue("ld_use", rt(6'd1, 5'd5, 5'd2, 5'd6),
          mk(6, 0, 7, 7, 0, 0, 0, 0, 1), 1);
    chk("ld_use_bubble", 64'(ov_seen), 0);
    issue("ld2", it(6'd36, 5'd1, 5'd5, 16'd0),
          mk(5, 32'h100, 0, 0, 0, 0, 1, 0, 1), 0);
    issue("ld_st", it(6'd37, 5'd1, 5'd5, 16'd4),
          mk(5, 32'h100, 4, 0, 0, 0, 0, 1, 0), 1);
    issue("ld3", it(6'd36, 5'd1, 5'd5, 16'd0),
          mk(5, 32'h100, 0, 0, 0, 0, 1, 0, 1), 0);
    issue("ld_addi", it(6'd32, 5'd2, 5'd5, 16'd1),
          mk(5, 7, 1, 0, 0, 0, 0, 0, 1), 0);
    issue("ld_r0", it(6'd36, 5'd1, 5'd0, 16'd0),
          mk(0, 32'h100, 0, 0, 0, 0, 1, 0, 1), 0);
    issue("r0_use", rt(6'd1, 5'd0, 5'd2, 5'd6),
          mk(6, 0, 7, 7, 0, 0, 0, 0, 1), 0);

    step();
    exe_ready = 1'b0;
    issue("hold", rt(6'd1, 5'd1, 5'd2, 5'd8),
          mk(8, 32'h100, 7, 7, 0, 0, 0, 0, 1), 0);
    instruction = rt(6'd3, 5'd2, 5'd3, 5'd9);
    in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 0);
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_dest", 64'(dest), 8);
      chk("hold_val1", 64'(val1), 32'h100);
      step();
    end
    exe_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 1);
    exp_q.push_back(mk(9, 7, 5, 5, 0, 2, 0, 0, 1));
    step();
    in_valid = 1'b0;

    step();
    exe_ready = 1'b0;
    issue("pre_flush", rt(6'd8, 5'd1, 5'd2, 5'd10),
          mk(10, 32'h100, 7, 7, 0, 6, 0, 0, 1), 0);
    instruction = rt(6'd6, 5'd1, 5'd2, 5'd11);
    in_valid    = 1'b1;
    flush       = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 0);
    void'(exp_q.pop_back());
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    exe_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 0);
    step();
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush2_in_ready", 64'(in_ready), 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", 64'(out_valid), 0);
    step();

    wb_write_en = 1'b1;
    wb_dest     = 5'd7;
    wb_data     = A5;
    issue("byp_same", rt(6'd1, 5'd7, 5'd7, 5'd11),
          mk(11, R7_SAME, R7_SAME, R7_SAME, 0, 0, 0, 0, 1), 0);
    wb_write_en = 1'b0;
    issue("byp_after", rt(6'd1, 5'd7, 5'd0, 5'd12),
          mk(12, A5, 0, 0, 0, 0, 0, 0, 1), 0);
    wb_write_en = 1'b1;
    wb_dest     = 5'd0;
    wb_data     = 32'hDEAD_BEEF;
    issue("r0_same", rt(6'd1, 5'd0, 5'd7, 5'd13),
          mk(13, 0, A5, A5, 0, 0, 0, 0, 1), 0);
    wb_write_en = 1'b0;
    issue("r0_after", rt(6'd1, 5'd0, 5'd0, 5'd14),
          mk(14, 0, 0, 0, 0, 0, 0, 0, 1), 0);

    step();
    rst         = 1'b1;
    flush       = 1'b1;
    wb_write_en = 1'b1;
    wb_dest     = 5'd3;
    wb_data     = 32'h55;
    step();
    rst         = 1'b0;
    flush       = 1'b0;
    wb_write_en = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 0);
    chk("rst2_val1", 64'(val1), 0);
    step();
    issue("rst_clears", rt(6'd1, 5'd3, 5'd1, 5'd15),
          mk(15, 0, 0, 0, 0, 0, 0, 0, 1), 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("drain", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
